// File: rtl/array_access_ctrl_if.sv
// Request/response channels between a client and array_access_ctrl:
// masked write, read request, and the in-order read response stream.
interface array_access_ctrl_if #(
    parameter int WIDTH  = 192,
    parameter int SEGS   = 8,
    parameter int ADDR_W = 7
);
    logic              w_valid;
    logic              w_ready;
    logic [ADDR_W-1:0] w_addr;
    logic [WIDTH-1:0]  w_data;
    logic [SEGS-1:0]   w_mask;

    logic              r_req_valid;
    logic              r_req_ready;
    logic [ADDR_W-1:0] r_req_addr;

    logic              r_resp_valid;
    logic              r_resp_ready;
    logic [WIDTH-1:0]  r_resp_data;

    modport master (
        output w_valid, w_addr, w_data, w_mask,
        output r_req_valid, r_req_addr, r_resp_ready,
        input  w_ready, r_req_ready, r_resp_valid, r_resp_data
    );

    modport slave (
        input  w_valid, w_addr, w_data, w_mask,
        input  r_req_valid, r_req_addr, r_resp_ready,
        output w_ready, r_req_ready, r_resp_valid, r_resp_data
    );
endinterface

// File: rtl/array_access_ctrl.sv
// Single-port array controller: zero-fills the array after reset, then arbitrates
// masked writes and reads, returning read data through a 2-entry in-order FIFO.
module array_access_ctrl #(
    parameter int DEPTH  = 128,
    parameter int WIDTH  = 192,
    parameter int SEGS   = 8,
    parameter int ADDR_W = 7
) (
    input  logic              clock,
    input  logic              reset,
    array_access_ctrl_if.slave bus,
    output logic              init_done,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [SEGS-1:0]   sram_wmask,
    output logic [WIDTH-1:0]  sram_wdata,
    input  logic [WIDTH-1:0]  sram_rdata
);
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] fill_cnt_reg;
    logic              init_done_reg;
    logic              inflight_reg;
    logic              wr_pri_reg;
    logic [1:0]        count_reg;
    logic              wr_ptr_reg;
    logic              rd_ptr_reg;
    logic [WIDTH-1:0]  fifo_mem_reg [2];

    logic       run;
    logic       deq;
    logic       enq;
    logic [2:0] pending;
    logic       rd_elig;
    logic       conflict;
    logic       wr_fire;
    logic       rd_fire;
    logic [1:0] count_next;

    // Gating with reset keeps every request-side output quiet during the reset cycle.
    assign run      = (state_reg == ST_RUN) && !reset;
    assign deq      = bus.r_resp_valid && bus.r_resp_ready;
    assign enq      = inflight_reg;
    assign pending  = {1'b0, count_reg} + {2'b00, inflight_reg};
    assign rd_elig  = run && (pending < (3'd2 + {2'b00, deq}));
    assign conflict = bus.w_valid && bus.r_req_valid && rd_elig;

    assign bus.w_ready     = run && !(bus.r_req_valid && rd_elig && !wr_pri_reg);
    assign bus.r_req_ready = rd_elig && !(bus.w_valid && wr_pri_reg);
    assign wr_fire         = bus.w_valid && bus.w_ready;
    assign rd_fire         = bus.r_req_valid && bus.r_req_ready;

    assign bus.r_resp_valid = (count_reg != 2'd0);
    assign bus.r_resp_data  = fifo_mem_reg[rd_ptr_reg];
    assign init_done        = init_done_reg;
    assign count_next       = count_reg + {1'b0, enq} - {1'b0, deq};

    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wmask = '0;
        sram_wdata = '0;
        if (!reset && state_reg == ST_INIT) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = fill_cnt_reg;
            sram_wmask = '1;
        end else if (wr_fire) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = bus.w_addr;
            sram_wmask = bus.w_mask;
            sram_wdata = bus.w_data;
        end else if (rd_fire) begin
            sram_en    = 1'b1;
            sram_addr  = bus.r_req_addr;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_INIT;
            fill_cnt_reg  <= '0;
            init_done_reg <= 1'b0;
            inflight_reg  <= 1'b0;
            wr_pri_reg    <= 1'b1;
            count_reg     <= 2'd0;
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    fill_cnt_reg <= fill_cnt_reg + 1'b1;
                    if (fill_cnt_reg == ADDR_W'(DEPTH - 1)) begin
                        state_reg     <= ST_RUN;
                        init_done_reg <= 1'b1;
                    end
                end
                default: state_reg <= ST_RUN;
            endcase
            inflight_reg <= rd_fire;
            // Only contested cycles hand priority to the loser.
            if (conflict) wr_pri_reg <= !wr_pri_reg;
            if (enq) wr_ptr_reg <= !wr_ptr_reg;
            if (deq) rd_ptr_reg <= !rd_ptr_reg;
            count_reg <= count_next;
        end
    end

    // Array read data is valid exactly one cycle after the read access.
    always_ff @(posedge clock) begin
        if (enq) fifo_mem_reg[wr_ptr_reg] <= sram_rdata;
    end
endmodule

// File: tb/tb_array_access_ctrl.sv
// Directed bench for array_access_ctrl with a behavioural masked array model.
`timescale 1ns/1ps
module tb_array_access_ctrl;
    localparam int DEPTH  = 128;
    localparam int WIDTH  = 192;
    localparam int SEGS   = 8;
    localparam int ADDR_W = 7;
    localparam int SEG_W  = WIDTH / SEGS;

    logic              clock;
    logic              reset;
    logic              init_done;
    logic              sram_en;
    logic              sram_wmode;
    logic [ADDR_W-1:0] sram_addr;
    logic [SEGS-1:0]   sram_wmask;
    logic [WIDTH-1:0]  sram_wdata;
    logic [WIDTH-1:0]  sram_rdata;
    logic [WIDTH-1:0]  mem [DEPTH];

    int n_vec;
    int n_err;

    array_access_ctrl_if #(.WIDTH(WIDTH), .SEGS(SEGS), .ADDR_W(ADDR_W)) bus ();

    array_access_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SEGS(SEGS), .ADDR_W(ADDR_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .init_done  (init_done),
        .sram_en    (sram_en),
        .sram_wmode (sram_wmode),
        .sram_addr  (sram_addr),
        .sram_wmask (sram_wmask),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode) begin
                for (int s = 0; s < SEGS; s++)
                    if (sram_wmask[s]) mem[sram_addr][s*SEG_W +: SEG_W] <= sram_wdata[s*SEG_W +: SEG_W];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic check_val(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.w_valid     = 1'b0;
        bus.r_req_valid = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] pat(input int a);
        logic [SEG_W-1:0] seg;
        seg = 24'hC0DE00 | SEG_W'(a);
        return {SEGS{seg}};
    endfunction

    task automatic do_write(input int a, input logic [WIDTH-1:0] d, input logic [SEGS-1:0] m);
        bus.w_valid = 1'b1;
        bus.w_addr  = ADDR_W'(a);
        bus.w_data  = d;
        bus.w_mask  = m;
        @(negedge clock);
        check_val("wr_ctrl", WIDTH'({bus.w_ready, sram_en, sram_wmode, sram_addr, sram_wmask}),
                  WIDTH'({1'b1, 1'b1, 1'b1, ADDR_W'(a), m}));
        check_val("wr_data", sram_wdata, d);
        $display("write addr=%0d mask=%h", a, m);
        tick();
        bus.w_valid = 1'b0;
    endtask

    task automatic do_read(input int a);
        bus.r_req_valid = 1'b1;
        bus.r_req_addr  = ADDR_W'(a);
        @(negedge clock);
        check_val("rd_ctrl", WIDTH'({bus.r_req_ready, sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata}),
                  WIDTH'({1'b1, 1'b1, 1'b0, ADDR_W'(a), {SEGS{1'b0}}, {WIDTH{1'b0}}}));
        $display("read  addr=%0d", a);
        tick();
        bus.r_req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input logic [WIDTH-1:0] exp);
        bit found;
        found = 1'b0;
        bus.r_resp_ready = 1'b1;
        for (int k = 0; k < 8 && !found; k++) begin
            @(negedge clock);
            if (bus.r_resp_valid) begin
                found = 1'b1;
                check_val(tag, bus.r_resp_data, exp);
                $display("resp  %s data=%h", tag, bus.r_resp_data);
            end
            tick();
        end
        if (!found) check_val({tag, "_timeout"}, WIDTH'(1'b0), WIDTH'(1'b1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus.w_valid = 1'b1;
        bus.r_req_valid = 1'b1;
        bus.w_addr = '0;
        bus.w_data = '0;
        bus.w_mask = '0;
        bus.r_req_addr = '0;
        bus.r_resp_ready = 1'b0;
        tick();
        @(negedge clock);
        check_val("reset_out", WIDTH'({init_done, bus.r_resp_valid, bus.w_ready, bus.r_req_ready, sram_en, sram_wmode, sram_wmask, sram_addr}),
                  WIDTH'(0));
        check_val("reset_wdata", sram_wdata, '0);
        tick();
        reset = 1'b0;

        // Zero-fill; requests held high must stay unaccepted.
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clock);
            check_val("init_ctrl", WIDTH'({sram_en, sram_wmode, sram_wmask, sram_addr, bus.w_ready, bus.r_req_ready, init_done}),
                      WIDTH'({1'b1, 1'b1, 8'hFF, ADDR_W'(i), 1'b0, 1'b0, 1'b0}));
            check_val("init_wdata", sram_wdata, '0);
            tick();
        end
        idle();
        @(negedge clock);
        check_val("init_done", WIDTH'(init_done), WIDTH'(1'b1));
        check_val("idle_ctrl", WIDTH'({sram_en, sram_wmode, sram_wmask, sram_addr}), WIDTH'(0));
        check_val("idle_wdata", sram_wdata, '0);
        tick();

        do_read(5);
        wait_resp("rd5_zero", '0);

        do_write(3, {SEGS{24'hAAAAAA}}, 8'h01);
        do_read(3);
        wait_resp("mask01", {168'b0, 24'hAAAAAA});

        // Both requesters held for four cycles: expect W,R,W,R.
        bus.r_resp_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bus.w_valid = 1'b1;
            bus.w_addr = 7'd20;
            bus.w_data = (c < 2) ? {SEGS{24'h111AAA}} : {SEGS{24'h222BBB}};
            bus.w_mask = 8'hFF;
            bus.r_req_valid = 1'b1;
            bus.r_req_addr = 7'd20;
            @(negedge clock);
            if (c % 2 == 0)
                check_val("arb_w", WIDTH'({bus.w_ready, bus.r_req_ready, sram_wmode, sram_en}), WIDTH'(4'b1011));
            else
                check_val("arb_r", WIDTH'({bus.w_ready, bus.r_req_ready, sram_wmode, sram_en}), WIDTH'(4'b0101));
            tick();
        end
        idle();
        wait_resp("arb_rd1", {SEGS{24'h111AAA}});
        wait_resp("arb_rd2", {SEGS{24'h222BBB}});

        // Backpressure: only two reads fit, head data holds while stalled.
        for (int k = 0; k < 4; k++) do_write(30 + k, pat(30 + k), 8'hFF);
        bus.r_resp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.r_req_valid = 1'b1;
            bus.r_req_addr = ADDR_W'(30 + k);
            @(negedge clock);
            check_val("bp_ready", WIDTH'(bus.r_req_ready), WIDTH'(k < 2));
            tick();
        end
        idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check_val("stall_hold", bus.r_resp_data, pat(30));
            check_val("stall_valid", WIDTH'(bus.r_resp_valid), WIDTH'(1'b1));
            tick();
        end
        wait_resp("bp_rd30", pat(30));
        wait_resp("bp_rd31", pat(31));
        @(negedge clock);
        check_val("bp_drained", WIDTH'(bus.r_resp_valid), WIDTH'(1'b0));
        tick();

        // Read-before-write ordering, then an all-zero mask write.
        do_write(9, {SEGS{24'h111111}}, 8'hFF);
        do_read(9);
        do_write(9, {SEGS{24'h222222}}, 8'hFF);
        wait_resp("rbw_old", {SEGS{24'h111111}});
        do_write(9, {SEGS{24'h333333}}, 8'h00);
        do_read(9);
        wait_resp("mask00", {SEGS{24'h222222}});

        // Reset with two responses queued.
        bus.r_resp_ready = 1'b0;
        do_read(40);
        do_read(41);
        tick();
        tick();
        @(negedge clock);
        check_val("queued2", WIDTH'(bus.r_resp_valid), WIDTH'(1'b1));
        reset = 1'b1;
        bus.w_valid = 1'b1;
        bus.r_req_valid = 1'b1;
        @(negedge clock);
        check_val("midrst_out", WIDTH'({sram_en, sram_wmode, sram_wmask, sram_addr, bus.w_ready, bus.r_req_ready}), WIDTH'(0));
        tick();
        reset = 1'b0;
        idle();
        @(negedge clock);
        check_val("rst_flush", WIDTH'({bus.r_resp_valid, init_done}), WIDTH'(0));
        check_val("reinit_a0", WIDTH'({sram_en, sram_wmode, sram_wmask, sram_addr}), WIDTH'({1'b1, 1'b1, 8'hFF, 7'd0}));
        tick();
        @(negedge clock);
        check_val("reinit_a1", WIDTH'(sram_addr), WIDTH'(7'd1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/array_access_ctrl.md
ARRAY_ACCESS_CTRL -- requirements
Module: array_access_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, 128, number of array entries.
REQ-002 SHALL have parameter WIDTH, 192, data bits per entry.
REQ-003 SHALL have parameter SEGS, 8, write-mask segments (WIDTH/SEGS = 24 bits each).
REQ-004 SHALL have parameter ADDR_W, 7, address width (log2 DEPTH).
REQ-005 clock  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 w_valid  in  1  write request valid.
REQ-008 w_ready  out  1  write request accepted when w_valid && w_ready.
REQ-009 w_addr  in  ADDR_W  write address.
REQ-010 w_data  in  WIDTH  write data.
REQ-011 w_mask  in  SEGS  per-segment write enable, bit i covers data[24i+23:24i].
REQ-012 r_req_valid  in  1  read request valid.
REQ-013 r_req_ready  out  1  read request accepted when r_req_valid && r_req_ready.
REQ-014 r_req_addr  in  ADDR_W  read address.
REQ-015 r_resp_valid  out  1  read response valid.
REQ-016 r_resp_ready  in  1  response consumed when r_resp_valid && r_resp_ready.
REQ-017 r_resp_data  out  WIDTH  read response data.
REQ-018 init_done  out  1  high once post-reset zero-fill is complete.
REQ-019 sram_en / sram_wmode  out  1 each  array port enable / write mode (1 = write).
REQ-020 sram_addr  out  ADDR_W; sram_wmask  out  SEGS; sram_wdata  out  WIDTH  array port request fields.
REQ-021 sram_rdata  in  WIDTH  array read data, valid the cycle after a read access.

Function
REQ-022 SHALL implement FSM states INIT and RUN; reset enters INIT with fill counter = 0.
REQ-023 In INIT, each cycle SHALL drive sram_en=1, sram_wmode=1, sram_wmask=all ones, sram_wdata=0, sram_addr=counter, then increment counter.
REQ-024 After the write to address DEPTH-1 (DEPTH cycles after reset release) SHALL enter RUN; init_done=1 from the first RUN cycle.
REQ-025 In INIT, w_ready=0 and r_req_ready=0.
REQ-026 In RUN, at most one array access per cycle; accepted request drives the array combinationally in the same cycle.
REQ-027 Accepted write SHALL drive sram_en=1, sram_wmode=1, sram_addr/wmask/wdata = w_addr/w_mask/w_data; all-zero mask forwarded unchanged.
REQ-028 Accepted read SHALL drive sram_en=1, sram_wmode=0, sram_addr=r_req_addr, sram_wmask=0, sram_wdata=0.
REQ-029 With no access, sram_en=0, sram_wmode=0, sram_addr=0, sram_wmask=0, sram_wdata=0.
REQ-030 Conflict (both valid, read eligible): priority alternates; write wins first conflict after init, loser wins next conflict; non-conflict cycles do not toggle priority.
REQ-031 Response path: one in-flight flag plus 2-entry in-order response FIFO; sram_rdata captured into FIFO the cycle after the read.
REQ-032 Read eligible only when FIFO occupancy + in-flight - (r_resp_valid && r_resp_ready) < 2; guarantees no overflow and 1 read/cycle with r_resp_ready held high.
REQ-033 r_resp_valid = FIFO non-empty; r_resp_data = FIFO head, stable while r_resp_valid && !r_resp_ready.
REQ-034 Write at cycle T to address A, read of A accepted at T+1 or later SHALL return new data; read accepted at T and write to A at T+1 SHALL return old data (captured value unaffected by later writes).
REQ-035 Simultaneous FIFO enqueue and dequeue SHALL keep occupancy unchanged and order intact.

Reset
REQ-036 Reset SHALL clear FIFO, in-flight flag, priority (write first) and fill counter, and enter INIT, including mid-operation; pending responses discarded.
REQ-037 Reset values: init_done=0, r_resp_valid=0, w_ready=0, r_req_ready=0; during the reset cycle sram_en=0 and all sram_* outputs 0.

Verification
REQ-038 Reset release -> 128 cycles of zero writes addr 0..127, mask 0xFF; init_done rises on cycle 129; a read of addr 5 returns 0.
REQ-039 Write addr 3 data 0xAA.. mask 0x01, next cycle read 3 -> response bits[23:0]=0xAAAAAA, bits[191:24]=0.
REQ-040 w_valid and r_req_valid held high 4 cycles -> accept order W,R,W,R; sram_wmode 1,0,1,0.
REQ-041 r_resp_ready=0, 4 back-to-back reads -> 2 accepted, r_req_ready=0 after; release ready -> responses in order, data stable while stalled.
REQ-042 Read addr 9 (holds 0x11..), next cycle write addr 9 0x22.. -> response 0x11...
REQ-043 Reset asserted with 2 responses queued -> r_resp_valid=0 next cycle, INIT restarts at addr 0.
